// File: rtl/go_conditioner_pkg.sv
// rtl/go_conditioner_pkg.sv - shared state encodings and operand index constants
package go_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } go_state_e;

  // Operand slots, shared with the downstream control FSM
  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

  function automatic logic [1:0] next_operand(input logic [1:0] idx);
    return (idx == OP_X) ? OP_A : idx + 2'd1;
  endfunction

endpackage

// File: rtl/go_conditioner_if.sv
// rtl/go_conditioner_if.sv - push-button/switch inputs and conditioned GO/operand outputs
interface go_conditioner_if #(
  parameter int DATA_W = 8
);
  logic              key_n;
  logic [DATA_W-1:0] sw_in;
  logic              go_out;
  logic              go_rise;
  logic              go_fall;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        operand_idx;
  logic              set_done;

  modport master (
    input  key_n, sw_in,
    output go_out, go_rise, go_fall, data_out, operand_idx, set_done
  );

  modport slave (
    output key_n, sw_in,
    input  go_out, go_rise, go_fall, data_out, operand_idx, set_done
  );
endinterface

// File: rtl/go_conditioner_sync_chain.sv
// rtl/go_conditioner_sync_chain.sv - parameterised flop chain for an asynchronous level
module go_conditioner_sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/go_conditioner.sv
// rtl/go_conditioner.sv - debounced GO button, frozen operand capture and operand index tracking
module go_conditioner
  import go_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int DATA_W          = 8
) (
  input  logic clk,
  input  logic reset,
  go_conditioner_if.master bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  go_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic              key_s;
  logic [DATA_W-1:0] sw_r;
  logic [DATA_W-1:0] data_q;
  logic              go_q;
  logic              rise_q;
  logic              fall_q;
  logic [1:0]        idx_q;
  logic              done_q;

  // Synchroniser resets to "released" so a held key is re-qualified after reset
  go_conditioner_sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .d     (~bus.key_n),
    .q     (key_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sw_r   <= '0;
      data_q <= '0;
      go_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      idx_q  <= OP_A;
      done_q <= 1'b0;
    end else begin
      sw_r   <= bus.sw_in;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        data_q <= sw_r;
      end
      case (state)
        ST_IDLE: begin
          if (key_s) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!key_s) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_HELD;
            go_q   <= 1'b1;
            rise_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!key_s) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (key_s) begin
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            // Accepted release: this is the edge the operand index advances on
            state  <= ST_IDLE;
            go_q   <= 1'b0;
            fall_q <= 1'b1;
            idx_q  <= next_operand(idx_q);
            done_q <= (idx_q == OP_X);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.go_out      = go_q;
  assign bus.go_rise     = rise_q;
  assign bus.go_fall     = fall_q;
  assign bus.data_out    = data_q;
  assign bus.operand_idx = idx_q;
  assign bus.set_done    = done_q;

endmodule
